// File: rtl/mc_control_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, FSM states and
// datapath mux/ALU select codes.
package mc_control_pkg;

  localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
  localparam logic [6:0] OPCODE_R       = 7'b0110011;
  localparam logic [6:0] OPCODE_I_ARITH = 7'b0010011;
  localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL     = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR    = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WR   = 4'd4,
    ST_WB_MEM   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_EXEC_I   = 4'd7,
    ST_WB_ALU   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_JALR     = 4'd11,
    ST_LUI      = 4'd12,
    ST_AUIPC    = 4'd13,
    ST_TRAP     = 4'd14
  } state_t;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_TARGET = 2'b01;
  localparam logic [1:0] PC_SRC_JALR   = 2'b10;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;

  // Dispatch target out of DECODE; anything unrecognised traps.
  function automatic state_t decode_state(input logic [6:0] op);
    state_t st;
    case (op)
      OPCODE_LOAD:    st = ST_MEM_ADDR;
      OPCODE_STORE:   st = ST_MEM_ADDR;
      OPCODE_R:       st = ST_EXEC_R;
      OPCODE_I_ARITH: st = ST_EXEC_I;
      OPCODE_BRANCH:  st = ST_BRANCH;
      OPCODE_JAL:     st = ST_JAL;
      OPCODE_JALR:    st = ST_JALR;
      OPCODE_LUI:     st = ST_LUI;
      OPCODE_AUIPC:   st = ST_AUIPC;
      default:        st = ST_TRAP;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mc_control.sv
// Multi-cycle RISC-V style control FSM: Moore outputs decoded from the state
// register, qualified by mem_ready/branch_taken, plus a retired-instruction count.
module mc_control
  import mc_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        target_write,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [31:0] instret
);

  state_t      state_r;
  state_t      next_state_s;
  logic [31:0] instret_r;
  logic        retire_s;

  assign instret  = instret_r;
  assign retire_s = (state_r != ST_FETCH) && (next_state_s == ST_FETCH);

  // State register and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_FETCH;
      instret_r <= 32'd0;
    end else begin
      state_r <= next_state_s;
      if (retire_s) begin
        instret_r <= instret_r + 32'd1;
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  // Next-state selection; memory states wait on mem_ready, TRAP is absorbing.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_FETCH:    next_state_s = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE:   next_state_s = decode_state(opcode);
      ST_MEM_ADDR: next_state_s = (opcode == OPCODE_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   next_state_s = mem_ready ? ST_WB_MEM : ST_MEM_RD;
      ST_MEM_WR:   next_state_s = mem_ready ? ST_FETCH : ST_MEM_WR;
      ST_WB_MEM:   next_state_s = ST_FETCH;
      ST_EXEC_R:   next_state_s = ST_WB_ALU;
      ST_EXEC_I:   next_state_s = ST_WB_ALU;
      ST_AUIPC:    next_state_s = ST_WB_ALU;
      ST_WB_ALU:   next_state_s = ST_FETCH;
      ST_BRANCH:   next_state_s = ST_FETCH;
      ST_JAL:      next_state_s = ST_FETCH;
      ST_JALR:     next_state_s = ST_FETCH;
      ST_LUI:      next_state_s = ST_FETCH;
      ST_TRAP:     next_state_s = ST_TRAP;
      default:     next_state_s = ST_TRAP;
    endcase
  end

  // Output decode; everything is forced low while rst is high so an
  // in-flight memory request is dropped in the reset cycle itself.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_ALU;
    alu_src_a    = SRC_A_PC;
    alu_src_b    = SRC_B_RS2;
    alu_op       = ALU_OP_ADD;
    target_write = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = WB_SEL_ALU;
    illegal      = 1'b0;
    if (rst) begin
      mem_req = 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRC_B_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        ST_DECODE: begin
          alu_src_a    = SRC_A_OLD_PC;
          alu_src_b    = SRC_B_IMM;
          target_write = 1'b1;
        end
        ST_MEM_ADDR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
        end
        ST_MEM_RD: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
        end
        ST_MEM_WR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 1'b1;
        end
        ST_WB_MEM: begin
          reg_write = 1'b1;
          wb_sel    = WB_SEL_MEM;
        end
        ST_EXEC_R: begin
          alu_src_a = SRC_A_RS1;
          alu_op    = ALU_OP_RTYPE;
        end
        ST_EXEC_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_OP_ITYPE;
        end
        ST_AUIPC: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
        end
        ST_WB_ALU: begin
          reg_write = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a = SRC_A_RS1;
          alu_op    = ALU_OP_BRANCH;
          pc_write  = branch_taken;
          pc_src    = PC_SRC_TARGET;
        end
        ST_JAL: begin
          reg_write = 1'b1;
          wb_sel    = WB_SEL_PC4;
          pc_write  = 1'b1;
          pc_src    = PC_SRC_TARGET;
        end
        ST_JALR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          reg_write = 1'b1;
          wb_sel    = WB_SEL_PC4;
          pc_write  = 1'b1;
          pc_src    = PC_SRC_JALR;
        end
        ST_LUI: begin
          reg_write = 1'b1;
          wb_sel    = WB_SEL_IMM;
        end
        ST_TRAP: begin
          illegal = 1'b1;
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

endmodule
